// File: rtl/axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo
//
// Synchronous AXI-Stream FIFO with optional store-and-forward packet mode.
// Each entry holds one beat: data, keep, strb, last and user.
//
// Parameters
//   DATA_WIDTH       stream data width, multiple of 8
//   USER_WIDTH       sideband user width, >= 1
//   DEPTH            entry count, power of 2 in 2..4096
//   ALMOST_FULL_TH   almost_full when data_count >= this (1..DEPTH-1)
//   ALMOST_EMPTY_TH  almost_empty when data_count <= this (1..DEPTH-1)
//   PACKET_MODE      0: cut-through; 1: output held until a whole packet
//                    (a beat with last=1) is stored
//
// Ports
//   clk, rst                     single clock, synchronous active-high reset
//   s_axis_* (data/keep/strb/last/user, valid, ready)   write side
//   m_axis_* (data/keep/strb/last/user, valid, ready)   read side
//   data_count                   stored beat count
//   pkt_count                    stored beats with last=1
//   almost_full, almost_empty    threshold flags from registered data_count
//
// Handshake: a beat transfers on a rising edge where valid=1 and ready=1.
// valid never depends on ready, and ready/valid here are functions of
// registered state and rst only, so there is no combinational path from
// m_axis_ready to s_axis_ready or the reverse.
// -----------------------------------------------------------------------------
module axis_pkt_fifo #(
  parameter int DATA_WIDTH      = 32,
  parameter int USER_WIDTH      = 1,
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_TH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter int PACKET_MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_axis_data,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_keep,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_strb,
  input  logic                      s_axis_last,
  input  logic [USER_WIDTH-1:0]     s_axis_user,
  input  logic                      s_axis_valid,
  output logic                      s_axis_ready,
  output logic [DATA_WIDTH-1:0]     m_axis_data,
  output logic [DATA_WIDTH/8-1:0]   m_axis_keep,
  output logic [DATA_WIDTH/8-1:0]   m_axis_strb,
  output logic                      m_axis_last,
  output logic [USER_WIDTH-1:0]     m_axis_user,
  output logic                      m_axis_valid,
  input  logic                      m_axis_ready,
  output logic [$clog2(DEPTH):0]    data_count,
  output logic [$clog2(DEPTH):0]    pkt_count,
  output logic                      almost_full,
  output logic                      almost_empty
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 2 * KW + 1 + USER_WIDTH;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_TH);

  // Storage is not reset: pointers and counts define which entries are live.
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] data_count_q, data_count_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  // Set when the FIFO is full of a packet with no last beat stored; lets that
  // oversize packet drain cut-through instead of deadlocking.
  logic          forced_q, forced_d;

  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;
  logic          head_last;
  logic          out_avail;
  logic          wr_en, rd_en;
  logic          wr_last, rd_last;

  // Entry layout: {data, keep, strb, last, user}; last sits at bit USER_WIDTH.
  assign wr_entry   = {s_axis_data, s_axis_keep, s_axis_strb, s_axis_last, s_axis_user};
  assign head_entry = mem_q[rd_ptr_q];
  assign head_last  = head_entry[USER_WIDTH];

  assign {m_axis_data, m_axis_keep, m_axis_strb, m_axis_last, m_axis_user} = head_entry;

  always_comb begin
    out_avail = (data_count_q != '0);
    if (PACKET_MODE != 0) begin
      out_avail = out_avail && ((pkt_count_q != '0) || forced_q);
    end
  end

  assign s_axis_ready = !rst && (data_count_q < FULL_CNT);
  assign m_axis_valid = !rst && out_avail;

  assign wr_en   = s_axis_valid && s_axis_ready;
  assign rd_en   = m_axis_valid && m_axis_ready;
  assign wr_last = wr_en && s_axis_last;
  assign rd_last = rd_en && head_last;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;

    data_count_d = data_count_q;
    case ({wr_en, rd_en})
      2'b10:   data_count_d = data_count_q + CW'(1);
      2'b01:   data_count_d = data_count_q - CW'(1);
      default: data_count_d = data_count_q;
    endcase

    pkt_count_d = pkt_count_q;
    case ({wr_last, rd_last})
      2'b10:   pkt_count_d = pkt_count_q + CW'(1);
      2'b01:   pkt_count_d = pkt_count_q - CW'(1);
      default: pkt_count_d = pkt_count_q;
    endcase

    // Clear on reading a last beat; setting wins so that a full FIFO left
    // with no last beat after that read still drains.
    forced_d = forced_q;
    if (rd_last) begin
      forced_d = 1'b0;
    end
    if ((PACKET_MODE != 0) && (data_count_d == FULL_CNT) && (pkt_count_d == '0)) begin
      forced_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_count_q <= '0;
      pkt_count_q  <= '0;
      forced_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_count_q <= data_count_d;
      pkt_count_q  <= pkt_count_d;
      forced_q     <= forced_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign data_count   = data_count_q;
  assign pkt_count    = pkt_count_q;
  assign almost_full  = !rst && (data_count_q >= AF_CNT);
  assign almost_empty = rst || (data_count_q <= AE_CNT);

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_fifo
//
// Two instances share one stimulus: u_dut0 in cut-through mode and u_dut1 in
// packet mode, both DEPTH=8. A queue-based reference FIFO per instance
// predicts every output each cycle; directed literal checks pin the
// scenarios (reset, fill/drain, packet hold, concurrency, oversize packet,
// reset mid-packet).
// -----------------------------------------------------------------------------
module tb_axis_pkt_fifo;

  localparam int DW    = 16;
  localparam int KW    = DW / 8;
  localparam int UW    = 2;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int EW    = DW + 2 * KW + 1 + UW;

  // ---------------- clock / reset / stimulus signals ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic [KW-1:0] s_keep, s_strb;
  logic          s_last;
  logic [UW-1:0] s_user;
  logic          s_valid;
  logic          m_ready;

  logic          s_ready [2];
  logic [DW-1:0] m_data  [2];
  logic [KW-1:0] m_keep  [2];
  logic [KW-1:0] m_strb  [2];
  logic          m_last  [2];
  logic [UW-1:0] m_user  [2];
  logic          m_valid [2];
  logic [CW-1:0] dcnt    [2];
  logic [CW-1:0] pcnt    [2];
  logic          af      [2];
  logic          ae      [2];
  logic          dbg_forced;

  always #5 clk = ~clk;

  axis_pkt_fifo #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH),
    .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE), .PACKET_MODE(0)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .s_axis_data(s_data), .s_axis_keep(s_keep), .s_axis_strb(s_strb),
    .s_axis_last(s_last), .s_axis_user(s_user),
    .s_axis_valid(s_valid), .s_axis_ready(s_ready[0]),
    .m_axis_data(m_data[0]), .m_axis_keep(m_keep[0]), .m_axis_strb(m_strb[0]),
    .m_axis_last(m_last[0]), .m_axis_user(m_user[0]),
    .m_axis_valid(m_valid[0]), .m_axis_ready(m_ready),
    .data_count(dcnt[0]), .pkt_count(pcnt[0]),
    .almost_full(af[0]), .almost_empty(ae[0])
  );

  axis_pkt_fifo #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH),
    .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE), .PACKET_MODE(1)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .s_axis_data(s_data), .s_axis_keep(s_keep), .s_axis_strb(s_strb),
    .s_axis_last(s_last), .s_axis_user(s_user),
    .s_axis_valid(s_valid), .s_axis_ready(s_ready[1]),
    .m_axis_data(m_data[1]), .m_axis_keep(m_keep[1]), .m_axis_strb(m_strb[1]),
    .m_axis_last(m_last[1]), .m_axis_user(m_user[1]),
    .m_axis_valid(m_valid[1]), .m_axis_ready(m_ready),
    .data_count(dcnt[1]), .pkt_count(pcnt[1]),
    .almost_full(af[1]), .almost_empty(ae[1])
  );

  assign dbg_forced = u_dut1.forced_q;

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit log_en = 1'b0;
  logic [DW-1:0] got1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare process ----------------
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] mq[$];
  logic [EW-1:0] popped;
  bit            fm [2];
  int            cnt, pk;
  logic          e_sr, e_mv, e_af, e_ae, m_wr, m_rd;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (k == 0) mq = exp_q0; else mq = exp_q1;
      cnt = mq.size();
      pk = 0;
      foreach (mq[i]) if (mq[i][UW]) pk++;
      e_sr = !rst && (cnt < DEPTH);
      e_mv = !rst && (cnt > 0) && ((k == 0) || (pk > 0) || fm[k]);
      e_af = !rst && (cnt >= AF);
      e_ae = rst || (cnt <= AE);
      if (chk_en) begin
        chk($sformatf("s_ready%0d", k), 32'(s_ready[k]), 32'(e_sr));
        chk($sformatf("m_valid%0d", k), 32'(m_valid[k]), 32'(e_mv));
        chk($sformatf("data_count%0d", k), 32'(dcnt[k]), 32'(cnt));
        chk($sformatf("pkt_count%0d", k), 32'(pcnt[k]), 32'(pk));
        chk($sformatf("almost_full%0d", k), 32'(af[k]), 32'(e_af));
        chk($sformatf("almost_empty%0d", k), 32'(ae[k]), 32'(e_ae));
        if (e_mv) begin
          chk($sformatf("head_beat%0d", k),
              32'({m_data[k], m_keep[k], m_strb[k], m_last[k], m_user[k]}), 32'(mq[0]));
        end
        if (k == 1) chk("forced1", 32'(dbg_forced), 32'(fm[1]));
      end
      // advance the model across the coming rising edge
      if (rst) begin
        mq.delete();
        fm[k] = 1'b0;
      end else begin
        m_wr = s_valid && e_sr;
        m_rd = e_mv && m_ready;
        if (m_rd) begin
          popped = mq.pop_front();
          if (popped[UW]) fm[k] = 1'b0;
        end
        if (m_wr) mq.push_back({s_data, s_keep, s_strb, s_last, s_user});
        pk = 0;
        foreach (mq[i]) if (mq[i][UW]) pk++;
        if ((k == 1) && (mq.size() == DEPTH) && (pk == 0)) fm[k] = 1'b1;
      end
      if (k == 0) exp_q0 = mq; else exp_q1 = mq;
    end
  end

  // record beats leaving the packet-mode instance for the oversize scenario
  always @(negedge clk) begin
    if (log_en && !rst && m_valid[1] && m_ready) got1.push_back(m_data[1]);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [DW-1:0] d, input logic l);
    s_data  = d;
    s_keep  = d[1:0];
    s_strb  = ~d[2:1];
    s_user  = d[3:2] ^ 2'b01;
    s_last  = l;
    s_valid = 1'b1;
  endtask

  // hold a beat until the packet-mode instance accepts it
  task automatic push1(input logic [DW-1:0] d, input logic l);
    logic acc;
    int   n;
    set_beat(d, l);
    n = 0;
    do begin
      acc = s_ready[1];
      tick();
      n++;
    end while (!acc && n < 50);
    chk("push1_accept", 32'(acc), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; s_valid = 1'b1; s_data = 16'hdead; s_keep = '0; s_strb = '0;
    s_last = 1'b0; s_user = '0; m_ready = 1'b0;

    // reset held 3 cycles with a write attempted
    tick(); chk_en = 1'b1; tick(); tick();
    chk("rst_s_ready0", 32'(s_ready[0]), 32'd0);
    chk("rst_m_valid0", 32'(m_valid[0]), 32'd0);
    chk("rst_dcnt0", 32'(dcnt[0]), 32'd0);
    chk("rst_dcnt1", 32'(dcnt[1]), 32'd0);
    chk("rst_ae0", 32'(ae[0]), 32'd1);
    rst = 1'b0; s_valid = 1'b0; #1;
    chk("release_s_ready0", 32'(s_ready[0]), 32'd1);
    chk("release_s_ready1", 32'(s_ready[1]), 32'd1);

    // fill 0..7 (last on 7) with reads blocked
    for (int i = 0; i < 8; i++) begin
      set_beat(16'(i), i == 7);
      tick();
      if (i == 4) chk("af_cnt5", 32'(af[0]), 32'd0);
      if (i == 5) chk("af_cnt6", 32'(af[0]), 32'd1);
      if (i == 6) chk("pm1_hold_cnt7", 32'(m_valid[1]), 32'd0);
    end
    chk("full_s_ready0", 32'(s_ready[0]), 32'd0);
    chk("full_s_ready1", 32'(s_ready[1]), 32'd0);
    chk("full_dcnt0", 32'(dcnt[0]), 32'd8);
    chk("full_pm1_valid", 32'(m_valid[1]), 32'd1);
    set_beat(16'h0099, 1'b0);
    tick();
    chk("overfill_dcnt0", 32'(dcnt[0]), 32'd8);
    chk("overfill_dcnt1", 32'(dcnt[1]), 32'd8);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("drain_data0", 32'(m_data[0]), 32'(j));
      chk("drain_data1", 32'(m_data[1]), 32'(j));
      tick();
      if (j == 4) chk("ae_cnt3", 32'(ae[0]), 32'd0);
      if (j == 5) chk("ae_cnt2", 32'(ae[0]), 32'd1);
    end
    m_ready = 1'b0;
    chk("drained_dcnt0", 32'(dcnt[0]), 32'd0);
    chk("drained_dcnt1", 32'(dcnt[1]), 32'd0);

    // packet hold: 3 beats, last on the 3rd, reads enabled
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat(16'h00a0 + 16'(i), i == 2);
      tick();
      if (i < 2) chk("pkt_hold_valid1", 32'(m_valid[1]), 32'd0);
    end
    s_valid = 1'b0;
    chk("pkt_out0_valid", 32'(m_valid[1]), 32'd1);
    chk("pkt_out0_pcnt", 32'(pcnt[1]), 32'd1);
    chk("pkt_out0_data", 32'(m_data[1]), 32'h00a0);
    tick();
    chk("pkt_out1_valid", 32'(m_valid[1]), 32'd1);
    chk("pkt_out1_data", 32'(m_data[1]), 32'h00a1);
    tick();
    chk("pkt_out2_data", 32'(m_data[1]), 32'h00a2);
    chk("pkt_out2_last", 32'(m_last[1]), 32'd1);
    chk("pkt_out2_pcnt", 32'(pcnt[1]), 32'd1);
    tick();
    chk("pkt_done_valid", 32'(m_valid[1]), 32'd0);
    chk("pkt_done_pcnt", 32'(pcnt[1]), 32'd0);

    // concurrency: preload 4 beats (last on odd), then write+read 10 cycles
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_beat(16'h00b0 + 16'(i), i[0]);
      tick();
    end
    chk("conc_pre_dcnt1", 32'(dcnt[1]), 32'd4);
    chk("conc_pre_pcnt1", 32'(pcnt[1]), 32'd2);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_beat(16'h00c0 + 16'(i), i[0]);
      tick();
      chk("conc_dcnt0", 32'(dcnt[0]), 32'd4);
      chk("conc_pcnt0", 32'(pcnt[0]), 32'd2);
      chk("conc_dcnt1", 32'(dcnt[1]), 32'd4);
      chk("conc_pcnt1", 32'(pcnt[1]), 32'd2);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("conc_end_dcnt1", 32'(dcnt[1]), 32'd0);

    // oversize packet: 12 beats, last only on the 12th
    log_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push1(16'h00d0 + 16'(i), i == 11);
      if (i == 7) begin
        chk("ovs_forced_at8", 32'(dbg_forced), 32'd1);
        chk("ovs_dcnt_at8", 32'(dcnt[1]), 32'd8);
        chk("ovs_valid_at8", 32'(m_valid[1]), 32'd1);
      end
    end
    s_valid = 1'b0;
    n = 0;
    while (m_valid[1] && n < 40) begin
      tick();
      n++;
    end
    log_en = 1'b0;
    chk("ovs_forced_end", 32'(dbg_forced), 32'd0);
    chk("ovs_dcnt_end", 32'(dcnt[1]), 32'd0);
    chk("ovs_beats", 32'(got1.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk("ovs_order", (i < got1.size()) ? 32'(got1[i]) : 32'hffff_ffff, 32'h00d0 + 32'(i));
    end
    tick(); tick();

    // reset mid-packet
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_beat(16'h00e0 + 16'(i), 1'b0);
      tick();
    end
    chk("mid_pre_dcnt0", 32'(dcnt[0]), 32'd5);
    chk("mid_pre_dcnt1", 32'(dcnt[1]), 32'd5);
    chk("mid_pre_valid1", 32'(m_valid[1]), 32'd0);
    rst = 1'b1; s_valid = 1'b0;
    tick();
    rst = 1'b0; m_ready = 1'b1; #1;
    chk("mid_dcnt0", 32'(dcnt[0]), 32'd0);
    chk("mid_pcnt0", 32'(pcnt[0]), 32'd0);
    chk("mid_dcnt1", 32'(dcnt[1]), 32'd0);
    chk("mid_pcnt1", 32'(pcnt[1]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_stale0", 32'(m_valid[0]), 32'd0);
      chk("mid_no_stale1", 32'(m_valid[1]), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, stream data width; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter USER_WIDTH, default 1, sideband user width; it SHALL be at least 1.
REQ-003 The block SHALL have parameter DEPTH, default 16, entry count; it SHALL be a power of 2 from 2 to 4096.
REQ-004 The block SHALL have parameter ALMOST_FULL_TH, default DEPTH-2, almost-full level; it SHALL be in 1..DEPTH-1.
REQ-005 The block SHALL have parameter ALMOST_EMPTY_TH, default 2, almost-empty level; it SHALL be in 1..DEPTH-1.
REQ-006 The block SHALL have parameter PACKET_MODE, default 0; 1 holds output until a whole packet is stored.
REQ-007 The block SHALL have one clock; reset is synchronous and active-high.
REQ-008 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-009 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-010 The block SHALL have ports s_axis_data, s_axis_keep, s_axis_strb, s_axis_last and s_axis_user, inputs, widths DATA_WIDTH, DATA_WIDTH/8, DATA_WIDTH/8, 1 and USER_WIDTH, carrying the write beat.
REQ-011 The block SHALL have ports s_axis_valid (input, 1) and s_axis_ready (output, 1), the write handshake.
REQ-012 The block SHALL have ports m_axis_data, m_axis_keep, m_axis_strb, m_axis_last and m_axis_user, outputs, same widths as the write side, carrying the read beat.
REQ-013 The block SHALL have ports m_axis_valid (output, 1) and m_axis_ready (input, 1), the read handshake.
REQ-014 The block SHALL have port data_count, output, clog2(DEPTH)+1 bits, the stored beat count.
REQ-015 The block SHALL have port pkt_count, output, clog2(DEPTH)+1 bits, the number of stored beats with last=1.
REQ-016 The block SHALL have ports almost_full and almost_empty, outputs, 1 bit each, the threshold flags.

Function
REQ-017 A write SHALL occur on a rising edge with s_axis_valid=1 and s_axis_ready=1, storing data, keep, strb, last and user as one entry.
REQ-018 A read SHALL occur on a rising edge with m_axis_valid=1 and m_axis_ready=1, removing the head entry.
REQ-019 s_axis_ready SHALL equal (data_count<DEPTH) and not rst, combinationally from registered state.
REQ-020 Write and read pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 data_count SHALL rise by 1 on write-only, fall by 1 on read-only, and be unchanged on simultaneous write and read.
REQ-022 m_axis_* payload SHALL always present the head entry; its value is don't-care while m_axis_valid=0.
REQ-023 Latency, PACKET_MODE=0: a beat written at edge N SHALL drive m_axis_valid=1 after edge N (zero added cycles) when the FIFO was empty.
REQ-024 With PACKET_MODE=0, m_axis_valid SHALL equal (data_count>0).
REQ-025 pkt_count SHALL rise by 1 on a write with last=1, fall by 1 on a read with last=1, and be unchanged when both occur on one edge.
REQ-026 With PACKET_MODE=1, m_axis_valid SHALL equal (data_count>0) and (pkt_count>0 or forced).
REQ-027 The internal flag forced SHALL set when data_count=DEPTH and pkt_count=0 (PACKET_MODE=1 only).
REQ-028 forced SHALL clear on the edge at which a beat with last=1 is read.
REQ-029 forced SHALL prevent deadlock: an oversize packet drains in cut-through until its last beat.
REQ-030 almost_full SHALL equal (data_count>=ALMOST_FULL_TH), derived from registered data_count.
REQ-031 almost_empty SHALL equal (data_count<=ALMOST_EMPTY_TH), derived from registered data_count.
REQ-032 Writes while full and reads while m_axis_valid=0 SHALL NOT be possible; no overflow or underflow state exists.
REQ-033 Beat order SHALL be strictly preserved; keep, strb and user SHALL pass unmodified.

Reset
REQ-034 While rst=1 on an edge, pointers, data_count, pkt_count and forced SHALL clear to 0, and all stored contents are discarded.
REQ-035 While rst=1, s_axis_ready=0, m_axis_valid=0, almost_full=0 and almost_empty=1; handshakes SHALL be ignored.
REQ-036 Reset asserted mid-packet SHALL discard partial packets with no residual beat output afterwards.
REQ-037 In the first cycle after rst deasserts, s_axis_ready SHALL be 1.

Verification
REQ-038 Reset check: rst=1 for 3 cycles with s_axis_valid=1 -> s_axis_ready=0, m_axis_valid=0, data_count=0; in the first cycle after release s_axis_ready=1.
REQ-039 Fill/drain check (DEPTH=8, ALMOST_FULL_TH=6, PACKET_MODE=0): write 0x0..0x7 with m_axis_ready=0 -> almost_full=1 at count 6, s_axis_ready=0 at count 8; then drain -> data 0x0..0x7 in order, and almost_empty=1 at count 2.
REQ-040 Packet-hold check (PACKET_MODE=1): write 3 beats, last on the 3rd, with m_axis_ready=1 -> m_axis_valid=0 until the edge accepting the 3rd beat, then 3 consecutive output beats, pkt_count 1 then 0.
REQ-041 Concurrency check: at data_count=4, hold write and read active for 10 cycles -> data_count stays 4 and pkt_count stays constant with last=1 on both sides.
REQ-042 Oversize check (PACKET_MODE=1, DEPTH=8): write 12 beats, last only on the 12th -> forced=1 at count 8, m_axis_valid=1, all 12 beats delivered in order, forced=0 after the last beat.
REQ-043 Reset-mid-op check: store 5 beats of an unfinished packet, pulse rst for 1 cycle -> data_count=0, pkt_count=0, and no stale beat appears on m_axis.
